// File: rtl/pool_row_fifo_pkg.sv
// Shared definitions for the pooling-row FIFO: default element width,
// a constant-friendly clog2 and the lane packing offset helper.
package pool_row_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  // Ceiling log2. Usable in parameter context; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // LSB position of lane k inside a LANES*dw packed word.
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/pool_row_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer. clr wins over inc; wraps DEPTH-1 -> 0 so
// non-power-of-2 depths never address past the last entry.
module fifo_wrap_ptr #(
  parameter int DEPTH      = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  // Pointer register with explicit wrap at the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pool_row_fifo.sv
// Multi-lane row FIFO between the conv/pool combiner and the next-row
// pooling compare. All lanes share one pair of pointers and one count.
module pool_row_fifo
  import pool_row_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = 4,
  parameter int DEPTH      = 10,
  parameter int AF_LEVEL   = DEPTH - 1,
  localparam int ADDR_WIDTH = clog2(DEPTH),
  localparam int CNT_WIDTH  = clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]        count,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        overflow_err
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_CNT    = CNT_WIDTH'(AF_LEVEL);

  logic [LANES*DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0]       wr_ptr;
  logic [ADDR_WIDTH-1:0]       rd_ptr;
  logic                        wr_en;
  logic                        rd_en;

  // Status flags are pure decodes of the occupancy count.
  always_comb begin
    full        = (count == DEPTH_CNT);
    empty       = (count == '0);
    almost_full = (count >= AF_CNT);
    in_ready    = !full;
    out_valid   = !empty;
    // Flush swallows any transfer offered in the same cycle.
    wr_en       = in_valid && in_ready && !flush;
    rd_en       = out_valid && out_ready && !flush;
    out_data    = empty ? '0 : mem[rd_ptr];
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // Occupancy count and sticky overflow; flush clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (in_valid && full) overflow_err <= 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
